tetris_move_scheduler: RTL and testbench
========================================

# tetris_move_scheduler

Frame-synchronous motion scheduler for the falling Tetris piece. Arbitrates player button requests against the gravity timer and the collision feedback, and commits at most one move per video frame. Drives the piece reference coordinates (`x_cor`/`y_cor`) consumed by `vga_controller`. All updates land during vertical sync, so each rendered frame sees stable coordinates.

## Interface
Parameters (name, default, meaning):
- `CELL`, 16: pixel step per move.
- `X_MIN`, 0: leftmost legal `x_cor`.
- `X_MAX`, 144: rightmost legal `x_cor`.
- `X_SPAWN`, 64: spawn `x_cor`.
- `Y_SPAWN`, 0: spawn `y_cor`.
- `Y_MAX`, 304: lowest legal `y_cor`.
- `GRAVITY_FRAMES`, 30: frames per forced down step.
- `REPEAT_FRAMES`, 8: autorepeat period, in frames.

Ports (name, direction, width, meaning):
- `iVGA_CLK`, in, 1: pixel clock; the only clock.
- `iRST_n`, in, 1: reset, asynchronous, active-low.
- `iVS`, in, 1: active-low vsync from `video_sync_generator`.
- `up`, `left`, `down`, `right`, in, 1 each: button levels, asynchronous.
- `hit`, in, 1: collision below the piece, from `color_mux`.
- `stop`, in, 1: playfield overflow, from `color_mux`.
- `start_over`, in, 1: restart request, asynchronous.
- `x_cor`, `y_cor`, out, 10 each: piece reference position.
- `rotate_req`, out, 1: one-cycle pulse; drives `change_shape`.
- `lock_pulse`, out, 1: one-cycle pulse when the piece lands.
- `game_over`, out, 1: level, high in GAMEOVER.

## Operation
Input conditioning:
- Every button, `start_over` and `iVS` passes through a 2-flop synchronizer.
- The frame tick is the falling edge of the synchronized `iVS`.

States:
- **SPAWN**: load `x_cor=X_SPAWN`, `y_cor=Y_SPAWN`; clear the gravity counter. Go to FALL on the next tick.
- **FALL**: on each tick, evaluate one move using this priority: down > left > right > up.
  - down is either a user down request or the gravity counter reaching `GRAVITY_FRAMES-1`.
  - Gravity counter resets on any committed down move. Otherwise it increments once per tick.
- **LOCK**: hold position for one tick. Pulse `lock_pulse` on entry, then go to SPAWN.
- **GAMEOVER**: coordinates frozen, `game_over=1`. Leave only on `start_over`.

Move rules in FALL:
- **Down**:
  - If `hit=1` or `y_cor==Y_MAX`, go to LOCK; `y_cor` is unchanged.
  - Otherwise `y_cor += CELL`.
- **Left**: if `x_cor==X_MIN`, ignore; otherwise `x_cor -= CELL`.
- **Right**: if `x_cor==X_MAX`, ignore; otherwise `x_cor += CELL`.
- **Left and right together**: both ignored; lower-priority up is still evaluated.
- **Up**: pulse `rotate_req`; coordinates unchanged.

Other events:
- `stop=1` sampled at any tick, in any state except GAMEOVER: go to GAMEOVER. This overrides the move.
- `start_over` has the highest priority. It is checked every cycle (not tick-gated) and forces SPAWN.
- A request counts as pending if its button rose since the previous tick. With autorepeat, a held button is also pending (see Configuration).
- Arithmetic is unsigned 10-bit. Bounds checks occur before add/subtract, so no wrap can occur.

## Timing
- Tick is asserted 3 cycles after `iVS` falls: 2 sync flops plus the edge register.
- `x_cor`, `y_cor`, `rotate_req` and `lock_pulse` are registered. They change on the cycle after the tick.
- A button pressed at least 3 cycles before the tick is seen at that tick. Presses inside that window are seen at the following tick.
- The gravity step occurs exactly every `GRAVITY_FRAMES` ticks with no input.
- Reset values:
  - `x_cor=X_SPAWN`, `y_cor=Y_SPAWN`.
  - `rotate_req=0`, `lock_pulse=0`, `game_over=0`.
  - State SPAWN; all counters and synchronizers 0.
- Reset mid-operation discards pending requests and the gravity count.

## Configuration
- `SCHED_AUTOREPEAT_EN` defined: a button held across ticks re-issues its request every `REPEAT_FRAMES` ticks, starting `REPEAT_FRAMES` ticks after the rising edge. Applies to left, right and down only; up never repeats.
- Undefined: all requests are rising-edge only. Holding a button produces exactly one move.

## Structure
- Package `tetris_sched_pkg` holds:
  - the state enum (SPAWN, FALL, LOCK, GAMEOVER);
  - the default values for `CELL`, `X_*`, `Y_*`, `GRAVITY_FRAMES` and `REPEAT_FRAMES`.
- Sub-module `btn_repeat`: one instance per direction button. It contains the synchronizer, edge detect and optional repeat counter, and outputs `pending`, which is cleared by the scheduler's `consume`.

## Test plan
- Reset, then 30 ticks with no input: `y_cor` 0→16 at tick 31; `x_cor` stays 64.
- Pulse left 5 times at `x_cor=64`, one per frame: `x_cor` goes 48, 32, 16, 0, then stays 0 on the 5th press.
- Hold left and right together for 4 ticks: `x_cor` unchanged and no `rotate_req`. Then press up alone: exactly one `rotate_req` pulse.
- Press down with `hit=1`: `y_cor` unchanged, `lock_pulse` one cycle after the tick, then `x_cor/y_cor=64/0` one tick later.
- `stop=1` at a tick: `game_over=1` and coordinates frozen for 100 ticks. Then `start_over`: `game_over=0`, spawn coordinates.
- With `SCHED_AUTOREPEAT_EN`, hold right for 20 ticks from `x_cor=64`: moves at ticks 1, 9 and 17, ending at `x_cor=112`. Without the macro: a single move to 80.

Source files
------------

// File: rtl/tetris_sched_pkg.sv
// rtl/tetris_sched_pkg.sv - shared state encoding and default geometry/timing for the move scheduler
package tetris_sched_pkg;

    typedef enum logic [1:0] {
        SPAWN    = 2'd0,
        FALL     = 2'd1,
        LOCK     = 2'd2,
        GAMEOVER = 2'd3
    } sched_state_t;

    localparam int SCHED_CELL           = 16;
    localparam int SCHED_X_MIN          = 0;
    localparam int SCHED_X_MAX          = 144;
    localparam int SCHED_X_SPAWN        = 64;
    localparam int SCHED_Y_SPAWN        = 0;
    localparam int SCHED_Y_MAX          = 304;
    localparam int SCHED_GRAVITY_FRAMES = 30;
    localparam int SCHED_REPEAT_FRAMES  = 8;

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button synchronizer, rising-edge latch and optional autorepeat
//
// Optional feature macro: SCHED_AUTOREPEAT_EN (held button re-arms every REPEAT_FRAMES ticks)
//
// Ports:
//   iVGA_CLK  pixel clock
//   iRST_n    asynchronous active-low reset
//   btn       raw asynchronous button level
//   consume   one-cycle frame tick from the scheduler; clears pending, paces autorepeat
//   pending   request waiting for the next tick
module btn_repeat #(
    parameter int REPEAT_FRAMES = 8,
    parameter bit ALLOW_REPEAT  = 1'b1
) (
    input  logic iVGA_CLK,
    input  logic iRST_n,
    input  logic btn,
    input  logic consume,
    output logic pending
);

    logic [1:0] sync_q;
    logic       held_d;
    logic       held;
    logic       rise;
    logic       fire;

    assign held = sync_q[1];
    assign rise = held & ~held_d;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync_q <= 2'b00;
            held_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            held_d <= held;
        end
    end

`ifdef SCHED_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);
    logic [RW-1:0] rep_cnt;

    // Fires on the tick that completes REPEAT_FRAMES ticks of holding, so the
    // re-armed request is serviced on the tick after that.
    assign fire = ALLOW_REPEAT && held && consume && (rep_cnt == RW'(REPEAT_FRAMES - 1));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rep_cnt <= '0;
        end else if (rise || !held) begin
            rep_cnt <= '0;
        end else if (consume) begin
            rep_cnt <= fire ? '0 : rep_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ALLOW_REPEAT ^ (REPEAT_FRAMES != 0);
    assign fire       = 1'b0;
`endif

    // A new request landing on the tick itself survives for the next tick.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pending <= 1'b0;
        end else if (rise || fire) begin
            pending <= 1'b1;
        end else if (consume) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/tetris_move_scheduler.sv
// rtl/tetris_move_scheduler.sv - frame-synchronous motion scheduler for the falling piece
//
// Optional feature macro: SCHED_AUTOREPEAT_EN (autorepeat for left/right/down)
//
// Ports:
//   iVGA_CLK, iRST_n              clock, asynchronous active-low reset
//   iVS                           active-low vsync; its falling edge is the frame tick
//   up, left, down, right         asynchronous button levels
//   hit, stop                     collision below piece / playfield overflow
//   start_over                    asynchronous restart request, acted on every cycle
//   x_cor, y_cor                  piece reference position
//   rotate_req, lock_pulse        one-cycle pulses after the tick
//   game_over                     high while in GAMEOVER
module tetris_move_scheduler
    import tetris_sched_pkg::*;
#(
    parameter int CELL           = SCHED_CELL,
    parameter int X_MIN          = SCHED_X_MIN,
    parameter int X_MAX          = SCHED_X_MAX,
    parameter int X_SPAWN        = SCHED_X_SPAWN,
    parameter int Y_SPAWN        = SCHED_Y_SPAWN,
    parameter int Y_MAX          = SCHED_Y_MAX,
    parameter int GRAVITY_FRAMES = SCHED_GRAVITY_FRAMES,
    parameter int REPEAT_FRAMES  = SCHED_REPEAT_FRAMES
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic       up,
    input  logic       left,
    input  logic       down,
    input  logic       right,
    input  logic       hit,
    input  logic       stop,
    input  logic       start_over,
    output logic [9:0] x_cor,
    output logic [9:0] y_cor,
    output logic       rotate_req,
    output logic       lock_pulse,
    output logic       game_over
);

    localparam int         GW      = $clog2(GRAVITY_FRAMES + 1);
    localparam logic [9:0] STEP    = 10'(CELL);
    localparam logic [9:0] XMIN_C  = 10'(X_MIN);
    localparam logic [9:0] XMAX_C  = 10'(X_MAX);
    localparam logic [9:0] XSPN_C  = 10'(X_SPAWN);
    localparam logic [9:0] YSPN_C  = 10'(Y_SPAWN);
    localparam logic [9:0] YMAX_C  = 10'(Y_MAX);

    logic [1:0]    vs_sync;
    logic          vs_d;
    logic          tick;
    logic [1:0]    so_sync;
    logic          start_s;

    sched_state_t  state, state_nxt;
    logic [GW-1:0] grav_cnt, grav_nxt;
    logic [9:0]    x_nxt, y_nxt;
    logic          rot_nxt, lock_nxt;
    logic          pend_up, pend_left, pend_down, pend_right;
    logic          want_down;

    assign start_s = so_sync[1];

    // Tick is registered: two sync flops, then a falling-edge compare into tick.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_sync <= 2'b00;
            vs_d    <= 1'b0;
            tick    <= 1'b0;
            so_sync <= 2'b00;
        end else begin
            vs_sync <= {vs_sync[0], iVS};
            vs_d    <= vs_sync[1];
            tick    <= vs_d & ~vs_sync[1];
            so_sync <= {so_sync[0], start_over};
        end
    end

    btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES), .ALLOW_REPEAT(1'b0)) u_btn_up (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .btn(up),    .consume(tick), .pending(pend_up));
    btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES), .ALLOW_REPEAT(1'b1)) u_btn_left (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .btn(left),  .consume(tick), .pending(pend_left));
    btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES), .ALLOW_REPEAT(1'b1)) u_btn_down (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .btn(down),  .consume(tick), .pending(pend_down));
    btn_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES), .ALLOW_REPEAT(1'b1)) u_btn_right (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .btn(right), .consume(tick), .pending(pend_right));

    assign want_down = pend_down || (grav_cnt == GW'(GRAVITY_FRAMES - 1));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= SPAWN;
            x_cor      <= XSPN_C;
            y_cor      <= YSPN_C;
            grav_cnt   <= '0;
            rotate_req <= 1'b0;
            lock_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            x_cor      <= x_nxt;
            y_cor      <= y_nxt;
            grav_cnt   <= grav_nxt;
            rotate_req <= rot_nxt;
            lock_pulse <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_cor;
        y_nxt     = y_cor;
        grav_nxt  = grav_cnt;
        rot_nxt   = 1'b0;
        lock_nxt  = 1'b0;
        if (start_s) begin
            state_nxt = SPAWN;
            x_nxt     = XSPN_C;
            y_nxt     = YSPN_C;
            grav_nxt  = '0;
        end else if (tick) begin
            if (stop && state != GAMEOVER) begin
                state_nxt = GAMEOVER;
            end else begin
                case (state)
                    SPAWN: begin
                        state_nxt = FALL;
                        grav_nxt  = '0;
                    end
                    FALL: begin
                        if (want_down) begin
                            grav_nxt = '0;
                            if (hit || y_cor == YMAX_C) begin
                                state_nxt = LOCK;
                                lock_nxt  = 1'b1;
                            end else begin
                                y_nxt = y_cor + STEP;
                            end
                        end else begin
                            grav_nxt = grav_cnt + 1'b1;
                            // A lone left/right claims the frame even when blocked
                            // at the wall; only the both-pressed case falls to up.
                            if (pend_left && !pend_right) begin
                                if (x_cor != XMIN_C) x_nxt = x_cor - STEP;
                            end else if (pend_right && !pend_left) begin
                                if (x_cor != XMAX_C) x_nxt = x_cor + STEP;
                            end else if (pend_up) begin
                                rot_nxt = 1'b1;
                            end
                        end
                    end
                    LOCK: begin
                        state_nxt = SPAWN;
                        x_nxt     = XSPN_C;
                        y_nxt     = YSPN_C;
                        grav_nxt  = '0;
                    end
                    GAMEOVER: ;
                    default: state_nxt = SPAWN;
                endcase
            end
        end
    end

    assign game_over = (state == GAMEOVER);

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// tb/tb_tetris_move_scheduler.sv - directed self-checking bench for tetris_move_scheduler
module tb_tetris_move_scheduler;

    logic       iVGA_CLK = 1'b0;
    logic       iRST_n;
    logic       iVS;
    logic       up, left, down, right;
    logic       hit, stop, start_over;
    logic [9:0] x_cor, y_cor;
    logic       rotate_req, lock_pulse, game_over;

    int n_vec     = 0;
    int n_miscmp  = 0;
    int rot_cnt   = 0;
    int lock_cnt  = 0;
    int rot_base;
    int lock_base;
    int exp_x;
    logic last_lock;

    tetris_move_scheduler dut (
        .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iVS(iVS),
        .up(up), .left(left), .down(down), .right(right),
        .hit(hit), .stop(stop), .start_over(start_over),
        .x_cor(x_cor), .y_cor(y_cor),
        .rotate_req(rotate_req), .lock_pulse(lock_pulse), .game_over(game_over)
    );

    always #5 iVGA_CLK = ~iVGA_CLK;

    always @(negedge iVGA_CLK) begin
        if (rotate_req) rot_cnt++;
        if (lock_pulse) lock_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: iVS low for 4 cycles then high for 6. The scheduler commits on
    // the 4th rising edge after the fall, so outputs are settled at the 4th negedge.
    task automatic frame();
        @(negedge iVGA_CLK) iVS = 1'b0;
        repeat (4) @(negedge iVGA_CLK);
        last_lock = lock_pulse;
        iVS = 1'b1;
        repeat (6) @(negedge iVGA_CLK);
    endtask

    task automatic press_left();
        @(negedge iVGA_CLK) left = 1'b1;
        repeat (3) @(negedge iVGA_CLK);
        left = 1'b0;
    endtask

    initial begin
        iRST_n = 1'b0; iVS = 1'b1;
        up = 0; left = 0; down = 0; right = 0;
        hit = 0; stop = 0; start_over = 0;
        repeat (3) @(negedge iVGA_CLK);
        check_eq("rst_x", int'(x_cor), 64);
        check_eq("rst_y", int'(y_cor), 0);
        check_eq("rst_rot", int'(rotate_req), 0);
        check_eq("rst_lock", int'(lock_pulse), 0);
        check_eq("rst_gameover", int'(game_over), 0);
        iRST_n = 1'b1;
        repeat (5) @(negedge iVGA_CLK);

        // tick 1 leaves SPAWN; gravity then fires on tick 31
        for (int i = 0; i < 30; i++) frame();
        check_eq("grav_y_t30", int'(y_cor), 0);
        frame();
        check_eq("grav_y_t31", int'(y_cor), 16);
        check_eq("grav_x_t31", int'(x_cor), 64);

        // five left presses from 64: 48 32 16 0 0
        for (int i = 0; i < 5; i++) begin
            press_left();
            frame();
            check_eq($sformatf("left_%0d", i), int'(x_cor), (i < 4) ? 48 - 16 * i : 0);
        end

        // left+right held together: no move, no rotate
        rot_base = rot_cnt;
        @(negedge iVGA_CLK) begin left = 1'b1; right = 1'b1; end
        for (int i = 0; i < 4; i++) frame();
        left = 1'b0; right = 1'b0;
        check_eq("lr_x", int'(x_cor), 0);
        check_eq("lr_rot", rot_cnt, rot_base);

        // up alone: one rotate pulse
        @(negedge iVGA_CLK) up = 1'b1;
        repeat (3) @(negedge iVGA_CLK);
        up = 1'b0;
        frame();
        frame();
        check_eq("up_rot", rot_cnt, rot_base + 1);

        // down with hit: lock, then respawn one tick later
        lock_base = lock_cnt;
        hit = 1'b1;
        @(negedge iVGA_CLK) down = 1'b1;
        repeat (3) @(negedge iVGA_CLK);
        down = 1'b0;
        frame();
        hit = 1'b0;
        check_eq("lock_y", int'(y_cor), 16);
        check_eq("lock_at_tick", int'(last_lock), 1);
        check_eq("lock_width", lock_cnt, lock_base + 1);
        frame();
        check_eq("respawn_x", int'(x_cor), 64);
        check_eq("respawn_y", int'(y_cor), 0);
        frame();

        // hold right for 20 ticks from 64
        @(negedge iVGA_CLK) right = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            frame();
`ifdef SCHED_AUTOREPEAT_EN
            exp_x = (t >= 17) ? 112 : (t >= 9) ? 96 : 80;
`else
            exp_x = 80;
`endif
            if (t == 1 || t == 8 || t == 9 || t == 16 || t == 17 || t == 20)
                check_eq($sformatf("hold_right_t%0d", t), int'(x_cor), exp_x);
        end
        right = 1'b0;
        check_eq("hold_right_y", int'(y_cor), 0);

        // stop: game over and frozen for 100 ticks, even with presses
        stop = 1'b1;
        frame();
        stop = 1'b0;
        check_eq("go_level", int'(game_over), 1);
        for (int i = 0; i < 100; i++) begin
            if (i == 10) press_left();
            if (i == 20) begin
                @(negedge iVGA_CLK) down = 1'b1;
                repeat (3) @(negedge iVGA_CLK);
                down = 1'b0;
            end
            frame();
        end
        check_eq("go_frozen_x", int'(x_cor), exp_x);
        check_eq("go_frozen_y", int'(y_cor), 0);
        check_eq("go_held", int'(game_over), 1);

        // start_over acts without a tick
        @(negedge iVGA_CLK) start_over = 1'b1;
        repeat (4) @(negedge iVGA_CLK);
        start_over = 1'b0;
        repeat (2) @(negedge iVGA_CLK);
        check_eq("restart_go", int'(game_over), 0);
        check_eq("restart_x", int'(x_cor), 64);
        check_eq("restart_y", int'(y_cor), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
